// File: rtl/windower_pkg.sv
// windower_pkg: shared types and elaboration helpers for the K-tap windower.
//   sample_t    - one sample at the default channel width
//   state_t     - windower control states
//   pad_beats() - look-ahead beats needed to cover half a kernel
//   win_width() - samples in one output window beat
package windower_pkg;

   localparam int NO_CH_DEFAULT = 2;

   typedef logic [NO_CH_DEFAULT-1:0] sample_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   function automatic int pad_beats(input int k, input int t);
      return (((k - 1) / 2) + t - 1) / t;
   endfunction

   function automatic int win_width(input int k, input int t);
      return t + k - 1;
   endfunction

endpackage

// File: rtl/window_shift_mem.sv
// window_shift_mem: DEPTH-beat shift register, T samples per beat, entry 0
// holds the oldest sample.
//   clk     - clock
//   en      - advance by one beat
//   pad_en  - load pad_beat instead of din on this advance
//   din     - incoming beat
//   pad_beat- padding beat inserted while flushing
//   nxt     - contents as they will be after this advance (used to build
//             the window in the same cycle the beat is loaded)
module window_shift_mem
   import windower_pkg::*;
#(
   parameter int NO_CH = 2,
   parameter int T     = 1,
   parameter int DEPTH = 3
) (
   input  logic                          clk,
   input  logic                          en,
   input  logic                          pad_en,
   input  logic [T-1:0][NO_CH-1:0]       din,
   input  logic [T-1:0][NO_CH-1:0]       pad_beat,
   output logic [DEPTH*T-1:0][NO_CH-1:0] nxt
);

   localparam int M = DEPTH * T;

   logic [M-1:0][NO_CH-1:0] mem;

   always_comb begin
      nxt = mem;
      for (int i = 0; i < M - T; i++) nxt[i] = mem[i+T];
      for (int i = 0; i < T; i++) nxt[M-T+i] = pad_en ? pad_beat[i] : din[i];
   end

   // Window contents are don't-care until filled, so no reset.
   always_ff @(posedge clk) begin
      if (en) mem <= nxt;
   end

endmodule

// File: rtl/windower_kn.sv
// windower_kn: streams 1D convolution windows of an odd KERNEL over images
// of 2^LOG2_IMG_SIZE samples, THROUGHPUT samples per beat, with valid/ready
// on both sides, self-flushing at end of image and zero/replicate padding.
//   clk, rst            - clock, synchronous active-low reset
//   in_vld/in_rdy       - input beat handshake
//   data_in             - input beat, index 0 earliest
//   out_vld/out_rdy     - output beat handshake
//   data_out            - window, index 0 = position jT-P
//   out_first/out_last  - output beat is first/last of the image
module windower_kn
   import windower_pkg::*;
#(
   parameter int NO_CH         = 2,
   parameter int LOG2_IMG_SIZE = 10,
   parameter int THROUGHPUT    = 1,
   parameter int KERNEL        = 3,
   parameter int PAD_MODE      = 0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_vld,
   output logic                                    in_rdy,
   input  logic [THROUGHPUT-1:0][NO_CH-1:0]        data_in,
   output logic                                    out_vld,
   input  logic                                    out_rdy,
   output logic [THROUGHPUT+KERNEL-2:0][NO_CH-1:0] data_out,
   output logic                                    out_first,
   output logic                                    out_last
);

   localparam int T     = THROUGHPUT;
   localparam int P     = (KERNEL - 1) / 2;
   localparam int F     = pad_beats(KERNEL, T);
   localparam int W     = win_width(KERNEL, T);
   localparam int DEPTH = 2 * F + 1;
   localparam int S     = 1 << LOG2_IMG_SIZE;
   localparam int CW    = LOG2_IMG_SIZE - $clog2(T);
   localparam int N     = 1 << CW;
   // Offset of position jT-P inside the memory once beat j+F is loaded.
   localparam int OFF   = F * T - P;

   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(F - 1);

   if (N < F + 1 || KERNEL < 3 || (KERNEL % 2) == 0) begin : g_cfg_err
      $error("windower_kn: unsupported KERNEL/THROUGHPUT/LOG2_IMG_SIZE combination");
   end

   state_t                       state, state_nxt;
   logic [CW-1:0]                in_cnt, out_cnt;
   logic                         accept, slot, produce, flush_adv;
   logic [NO_CH-1:0]             edge_l, edge_r;
   logic [T-1:0][NO_CH-1:0]      pad_beat;
   logic [DEPTH*T-1:0][NO_CH-1:0] nxt;
   logic [W-1:0][NO_CH-1:0]      win;

   assign slot      = !out_vld || out_rdy;
   assign accept    = in_vld && in_rdy;
   assign flush_adv = (state == FLUSH) && slot;

   // K >= 3 guarantees F >= 1, so FILL always has at least one beat to count.
   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      produce   = 1'b0;
      case (state)
         FILL: begin
            in_rdy = 1'b1;
            if (in_vld && in_cnt == FILL_LAST) state_nxt = RUN;
         end
         RUN: begin
            in_rdy  = slot;
            produce = in_vld && slot;
            if (in_vld && slot && in_cnt == CNT_LAST) state_nxt = FLUSH;
         end
         FLUSH: begin
            produce = slot;
            if (slot && out_cnt == CNT_LAST) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
      if (!rst) in_rdy = 1'b0;
   end

   always_comb begin
      for (int t = 0; t < T; t++) pad_beat[t] = (PAD_MODE == 1) ? edge_r : '0;
   end

   window_shift_mem #(.NO_CH(NO_CH), .T(T), .DEPTH(DEPTH)) u_mem (
      .clk      (clk),
      .en       (accept || flush_adv),
      .pad_en   (flush_adv),
      .din      (data_in),
      .pad_beat (pad_beat),
      .nxt      (nxt)
   );

   // Padding is decided by absolute position, so stale samples from a
   // previous image or flush never leak into the edge taps.
   always_comb begin
      for (int i = 0; i < W; i++) begin
         int pos;
         pos = int'(out_cnt) * T + i - P;
         if (pos < 0)       win[i] = (PAD_MODE == 1) ? edge_l : '0;
         else if (pos >= S) win[i] = (PAD_MODE == 1) ? edge_r : '0;
         else               win[i] = nxt[OFF+i];
      end
   end

   // Counters are N-periodic, so they return to zero after the last beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= FILL;
         in_cnt    <= '0;
         out_cnt   <= '0;
         out_vld   <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) in_cnt <= in_cnt + 1'b1;
         if (produce) begin
            out_vld   <= 1'b1;
            out_first <= (out_cnt == '0);
            out_last  <= (out_cnt == CNT_LAST);
            out_cnt   <= out_cnt + 1'b1;
         end else if (out_rdy) begin
            out_vld   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (produce) data_out <= win;
      if (accept && in_cnt == '0) edge_l <= data_in[0];
      if (accept && in_cnt == CNT_LAST) edge_r <= data_in[T-1];
   end

endmodule
